// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage access unit: request sizes, FSM states, latched request.
package mem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_RD_WAIT = 2'b01,
      ST_WR      = 2'b10,
      ST_RESP    = 2'b11
   } state_t;

   typedef struct packed {
      logic        write;
      size_t       size;
      logic        sgn;
      logic [1:0]  lo;
      logic [31:0] wdata;
   } req_t;

   // Reserved size is either rejected or aligned-checked as a full word.
   function automatic logic req_is_err(input size_t size, input logic [1:0] lo,
                                       input logic err_on_reserved);
      logic e;
      e = 1'b0;
      case (size)
         SZ_HALF: e = lo[0];
         SZ_WORD: e = (lo != 2'b00);
         SZ_RSVD: e = err_on_reserved ? 1'b1 : (lo != 2'b00);
         default: e = 1'b0;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/mem_access_unit_lane_extract_merge.sv
// Little-endian lane select: extends load data and merges sub-word store data into the old word.
// Purely combinational; reserved size behaves as a full word.
module lane_extract_merge
   import mem_pkg::*;
(
   input  logic [31:0] word_in,
   input  logic [31:0] wdata,
   input  logic [1:0]  lo,
   input  size_t       size,
   input  logic        sgn,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v    = word_in[7:0];
      half_v    = lo[1] ? word_in[31:16] : word_in[15:0];
      load_data = word_in;
      merged    = wdata;
      case (lo)
         2'd1:    byte_v = word_in[15:8];
         2'd2:    byte_v = word_in[23:16];
         2'd3:    byte_v = word_in[31:24];
         default: byte_v = word_in[7:0];
      endcase
      case (size)
         SZ_BYTE: begin
            load_data = sgn ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
            merged    = word_in;
            case (lo)
               2'd1:    merged[15:8]  = wdata[7:0];
               2'd2:    merged[23:16] = wdata[7:0];
               2'd3:    merged[31:24] = wdata[7:0];
               default: merged[7:0]   = wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            load_data = sgn ? {{16{half_v[15]}}, half_v} : {16'd0, half_v};
            merged    = word_in;
            if (lo[1]) merged[31:16] = wdata[15:0];
            else       merged[15:0]  = wdata[15:0];
         end
         default: begin
            load_data = word_in;
            merged    = wdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for a word-addressed memory without byte enables; sub-word stores run as RMW.
// Latency: error 1, word store 2, loads READ_WAIT+1, sub-word store READ_WAIT+2; req_ready only in IDLE.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int READ_WAIT       = 2,
   parameter bit ERR_ON_RESERVED = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] address,
   output logic [31:0] writedata,
   output logic        memwrite,
   output logic        memread,
   input  logic [31:0] readdata
);

   localparam int CW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

   state_t        state, state_nxt;
   req_t          req_q;
   logic [CW-1:0] cnt;
   logic          err_q;
   logic [31:0]   rdata_q;
   logic          accept, new_err, new_word_wr, sample;
   logic [31:0]   load_data, merged;

   assign new_err     = req_is_err(size_t'(req_size), req_addr[1:0], ERR_ON_RESERVED);
   assign new_word_wr = req_write && (size_t'(req_size) == SZ_WORD ||
                                      size_t'(req_size) == SZ_RSVD);

   lane_extract_merge u_lane (
      .word_in   (readdata),
      .wdata     (req_q.wdata),
      .lo        (req_q.lo),
      .size      (req_q.size),
      .sgn       (req_q.sgn),
      .load_data (load_data),
      .merged    (merged)
   );

   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      memread    = 1'b0;
      memwrite   = 1'b0;
      resp_valid = 1'b0;
      accept     = 1'b0;
      sample     = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept = 1'b1;
               if (new_err)          state_nxt = ST_RESP;
               else if (new_word_wr) state_nxt = ST_WR;
               else                  state_nxt = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            memread = 1'b1;
            if (cnt == '0) begin
               sample    = 1'b1;
               state_nxt = req_q.write ? ST_WR : ST_RESP;
            end
         end
         ST_WR: begin
            memwrite  = 1'b1;
            state_nxt = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            state_nxt  = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign resp_err   = resp_valid & err_q;
   assign resp_rdata = rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         req_q     <= '0;
         cnt       <= '0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
         address   <= '0;
         writedata <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            req_q     <= '{write: req_write, size: size_t'(req_size), sgn: req_signed,
                          lo: req_addr[1:0], wdata: req_wdata};
            cnt       <= CW'(READ_WAIT - 1);
            err_q     <= new_err;
            rdata_q   <= '0;
            address   <= {req_addr[31:2], 2'b00};
            writedata <= req_wdata;
         end else if (sample) begin
            if (req_q.write) writedata <= merged;
            else             rdata_q   <= load_data;
         end else if (state == ST_RD_WAIT) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

endmodule
